// File: rtl/data_mem_pkg.sv
// Shared CPU constants: ALU operation encodings, data-memory access types and
// the default data-memory depth.
package data_mem_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_HU = 3'b010;
    localparam logic [2:0] MEMOP_B  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;

    localparam int DM_DEPTH = 1024;

    // Codes above BU are reserved and always fault.
    function automatic logic memop_illegal(input logic [2:0] op);
        return op > MEMOP_BU;
    endfunction

endpackage

// File: rtl/data_mem_ext.sv
// Load path lane selection: picks the addressed half/byte out of a memory word
// and sign- or zero-extends it to 32 bits according to the access type.
module dm_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  memop,
    output logic [31:0] rd
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_sel = 8'h00;
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        rd = 32'h0;
        case (memop)
            MEMOP_W:  rd = word;
            MEMOP_H:  rd = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: rd = {16'h0, half_sel};
            MEMOP_B:  rd = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: rd = {24'h0, byte_sel};
            default:  rd = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte/halfword/word loads and stores,
// combinational reads, fault detection and asynchronous clear.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [2:0]  MemOp,
    output logic [31:0] RD,
    output logic        AddrErr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [31:0]   ext_word;
    logic [31:0]   merged;

    assign idx      = Addr[AW+1:2];
    assign lane     = Addr[1:0];
    assign cur_word = mem[idx];

    // Out-of-range addresses fault rather than aliasing onto low words.
    always_comb begin
        AddrErr = 1'b0;
        if ({1'b0, Addr} >= LIMIT)
            AddrErr = 1'b1;
        else if (memop_illegal(MemOp))
            AddrErr = 1'b1;
        else if ((MemOp == MEMOP_H || MemOp == MEMOP_HU) && Addr[0])
            AddrErr = 1'b1;
        else if (MemOp == MEMOP_W && lane != 2'b00)
            AddrErr = 1'b1;
    end

    dm_ext u_ext (
        .word  (cur_word),
        .lane  (lane),
        .memop (MemOp),
        .rd    (ext_word)
    );

    assign RD = AddrErr ? 32'h0 : ext_word;

    always_comb begin
        merged = cur_word;
        case (MemOp)
            MEMOP_W: merged = WD;
            MEMOP_H, MEMOP_HU: begin
                if (lane[1]) merged[31:16] = WD[15:0];
                else         merged[15:0]  = WD[15:0];
            end
            MEMOP_B, MEMOP_BU: begin
                case (lane)
                    2'd0: merged[7:0]   = WD[7:0];
                    2'd1: merged[15:8]  = WD[7:0];
                    2'd2: merged[23:16] = WD[7:0];
                    2'd3: merged[31:24] = WD[7:0];
                    default: merged = cur_word;
                endcase
            end
            default: merged = cur_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'h0;
        end else if (WE && !AddrErr) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: loads/stores of every width,
// faults, read-during-write and asynchronous reset behaviour.
module tb_data_mem;
    import data_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [2:0]  MemOp;
    logic [31:0] RD;
    logic        AddrErr;

    int checks;
    int failures;

    data_mem #(.DEPTH(1024)) dut (
        .clk     (clk),
        .reset   (reset),
        .WE      (WE),
        .Addr    (Addr),
        .WD      (WD),
        .MemOp   (MemOp),
        .RD      (RD),
        .AddrErr (AddrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a store, let it cross one rising edge, then drop WE.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        WE = 1'b1; MemOp = op; Addr = a; WD = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] a);
        WE = 1'b0; MemOp = op; Addr = a;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; WE = 1'b0; Addr = 32'h0; WD = 32'h0; MemOp = MEMOP_W;
        #2;
        checkOutput("reset_rd", RD, 32'h0);
        checkOutput("reset_err", {31'h0, AddrErr}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(MEMOP_W, 32'h10, 32'h8000_00F1);
        load(MEMOP_B, 32'h10);   checkOutput("lb_10",  RD, 32'hFFFF_FFF1);
        load(MEMOP_BU, 32'h10);  checkOutput("lbu_10", RD, 32'h0000_00F1);
        load(MEMOP_H, 32'h12);   checkOutput("lh_12",  RD, 32'hFFFF_8000);
        load(MEMOP_HU, 32'h12);  checkOutput("lhu_12", RD, 32'h0000_8000);
        load(MEMOP_H, 32'h10);   checkOutput("lh_10",  RD, 32'h0000_00F1);

        applyStimulus(MEMOP_B, 32'h20, 32'hFFFF_FF11);
        applyStimulus(MEMOP_BU, 32'h21, 32'h0000_0022);
        applyStimulus(MEMOP_B, 32'h22, 32'hAAAA_AA33);
        applyStimulus(MEMOP_B, 32'h23, 32'h0000_0044);
        load(MEMOP_W, 32'h20);   checkOutput("sb_fill", RD, 32'h4433_2211);
        load(MEMOP_BU, 32'h23);  checkOutput("lbu_23",  RD, 32'h0000_0044);

        WE = 1'b1; MemOp = MEMOP_W; Addr = 32'h22; WD = 32'hDEAD_BEEF;
        #1;
        checkOutput("sw_mis_err", {31'h0, AddrErr}, 32'h1);
        checkOutput("sw_mis_rd",  RD, 32'h0);
        @(posedge clk); #1; WE = 1'b0;
        load(MEMOP_W, 32'h20);   checkOutput("sw_mis_keep", RD, 32'h4433_2211);
        WE = 1'b1; MemOp = MEMOP_H; Addr = 32'h23; WD = 32'h0000_BEEF;
        #1;
        checkOutput("sh_mis_err", {31'h0, AddrErr}, 32'h1);
        @(posedge clk); #1; WE = 1'b0;
        load(MEMOP_W, 32'h20);   checkOutput("sh_mis_keep", RD, 32'h4433_2211);

        applyStimulus(MEMOP_W, 32'h0, 32'hCAFE_F00D);
        applyStimulus(MEMOP_W, 32'hFFC, 32'h1234_5678);
        load(MEMOP_W, 32'hFFC);  checkOutput("top_word", RD, 32'h1234_5678);
        checkOutput("top_err", {31'h0, AddrErr}, 32'h0);
        load(MEMOP_HU, 32'hFFE); checkOutput("top_hu", RD, 32'h0000_1234);
        WE = 1'b1; MemOp = MEMOP_W; Addr = 32'h1000; WD = 32'h5555_5555;
        #1;
        checkOutput("oor_err", {31'h0, AddrErr}, 32'h1);
        checkOutput("oor_rd",  RD, 32'h0);
        @(posedge clk); #1; WE = 1'b0;
        load(MEMOP_W, 32'h0);    checkOutput("no_wrap", RD, 32'hCAFE_F00D);
        load(3'b111, 32'h0);
        checkOutput("illegal_err", {31'h0, AddrErr}, 32'h1);
        checkOutput("illegal_rd",  RD, 32'h0);

        applyStimulus(MEMOP_W, 32'h30, 32'h0000_0001);
        WE = 1'b1; MemOp = MEMOP_W; Addr = 32'h30; WD = 32'h0000_0002;
        #1;
        checkOutput("rdw_before", RD, 32'h0000_0001);
        @(posedge clk); #1;
        checkOutput("rdw_after",  RD, 32'h0000_0002);
        WE = 1'b0;
        applyStimulus(MEMOP_H, 32'h32, 32'h0000_ABCD);
        load(MEMOP_W, 32'h30);   checkOutput("sh_merge", RD, 32'hABCD_0002);
        load(MEMOP_H, 32'h32);   checkOutput("lh_32",    RD, 32'hFFFF_ABCD);

        // Asynchronous clear between edges, then stores held off while reset is high.
        reset = 1'b1;
        #1;
        load(MEMOP_W, 32'h20);   checkOutput("rst_async_20",  RD, 32'h0);
        load(MEMOP_W, 32'hFFC);  checkOutput("rst_async_ffc", RD, 32'h0);
        load(MEMOP_W, 32'h1000); checkOutput("rst_err_oor", {31'h0, AddrErr}, 32'h1);
        applyStimulus(MEMOP_W, 32'h40, 32'h9999_9999);
        load(MEMOP_W, 32'h40);   checkOutput("rst_wins", RD, 32'h0);
        reset = 1'b0;
        applyStimulus(MEMOP_W, 32'h40, 32'h7777_0001);
        load(MEMOP_W, 32'h40);   checkOutput("first_after_rst", RD, 32'h7777_0001);
        load(MEMOP_W, 32'h10);   checkOutput("cleared_10", RD, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
